// File: rtl/mas_pkg.sv
// mas_pkg: shared datapath select codes, FSM states and modulus limits for mas_sched
package mas_pkg;

    localparam logic MAS_SEL_ADD = 1'b0;
    localparam logic MAS_SEL_SUB = 1'b1;

    localparam logic [4:0] Q_MIN = 5'd2;
    localparam logic [4:0] Q_MAX = 5'd8;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    function automatic logic q_legal(input logic [4:0] q);
        return (q >= Q_MIN) && (q <= Q_MAX);
    endfunction

endpackage

// File: rtl/mas_sched_mas_2input.sv
// MAS_2input: combinational modular add/subtract of two operands below Q
module MAS_2input
    import mas_pkg::*;
(
    input  logic [4:0] Din1,
    input  logic [4:0] Din2,
    input  logic [4:0] Q,
    input  logic       Sel,
    output logic [4:0] TDout,
    output logic [4:0] Dout
);

    // raw sum lies in 0..14, raw difference in -7..7 (bit 4 is the sign)
    assign TDout = (Sel == MAS_SEL_SUB) ? Din1 - Din2 : Din1 + Din2;
    assign Dout  = (Sel == MAS_SEL_SUB) ? (TDout[4] ? TDout + Q : TDout)
                                        : ((TDout >= Q) ? TDout - Q : TDout);

endmodule

// File: rtl/mas_sched.sv
// mas_sched: round-robin scheduler sharing one MAS_2input between two requesters
module mas_sched
    import mas_pkg::*;
#(
    parameter logic [4:0] Q_DEFAULT = 5'd7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       op0,
    input  logic       op1,
    input  logic [4:0] a0,
    input  logic [4:0] b0,
    input  logic [4:0] a1,
    input  logic [4:0] b1,
    output logic       ack0,
    output logic       ack1,
    input  logic       cfg_we,
    input  logic [4:0] cfg_q,
    output logic       cfg_err,
    output logic [4:0] q_cur,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [3:0] rsp_data,
    output logic       rsp_wrap,
    output logic       rsp_err
);

    state_t     state, state_n;
    logic       last, gnt, gid;
    logic       op_r, id_r, err_r;
    logic [4:0] a_r, b_r, q_r, a_g, b_g;
    logic [4:0] tdout, dout;

    assign q_cur = q_r;
    assign a_g   = gid ? a1 : a0;
    assign b_g   = gid ? b1 : b0;

    // the requester that was not granted last wins a tie
    always_comb begin
        gid     = req1 & ~(req0 & last);
        gnt     = (state == IDLE) && !cfg_we && (req0 || req1);
        state_n = (state == IDLE) ? (gnt ? EXEC : IDLE) : (state == EXEC) ? RESP : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last    <= 1'b1;
            q_r     <= Q_DEFAULT;
            op_r    <= 1'b0;
            id_r    <= 1'b0;
            err_r   <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            ack0    <= gnt && !gid;
            ack1    <= gnt && gid;
            cfg_err <= cfg_we && ((state != IDLE) || !q_legal(cfg_q));
            if (cfg_we && (state == IDLE) && q_legal(cfg_q)) q_r <= cfg_q;
            if (gnt) begin
                last  <= gid;
                id_r  <= gid;
                op_r  <= gid ? op1 : op0;
                a_r   <= a_g;
                b_r   <= b_g;
                err_r <= (a_g >= q_r) || (b_g >= q_r);
            end
        end
    end

    MAS_2input u_mas (
        .Din1  (a_r),
        .Din2  (b_r),
        .Q     (q_r),
        .Sel   (op_r ? MAS_SEL_SUB : MAS_SEL_ADD),
        .TDout (tdout),
        .Dout  (dout)
    );

    // response registers are loaded only at the end of EXEC and cleared otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_wrap  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= state == EXEC;
            rsp_id    <= (state == EXEC) && id_r;
            rsp_err   <= (state == EXEC) && err_r;
            rsp_data  <= ((state == EXEC) && !err_r) ? dout[3:0] : 4'd0;
            rsp_wrap  <= (state == EXEC) && !err_r && (tdout != dout);
        end
    end

endmodule

// File: tb/tb_mas_sched.sv
// tb_mas_sched: directed and randomized transactions against an arithmetic reference model
module tb_mas_sched;

    logic       clk = 1'b0, rst = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0, cfg_we = 1'b0;
    logic [4:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0, cfg_q = '0;
    logic       ack0, ack1, cfg_err, rsp_valid, rsp_id, rsp_wrap, rsp_err;
    logic [4:0] q_cur;
    logic [3:0] rsp_data;

    int checks = 0, failures = 0, cyc = 0;
    int mq = 7, mlast = 1;

    mas_sched dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .ack0(ack0), .ack1(ack1),
        .cfg_we(cfg_we), .cfg_q(cfg_q), .cfg_err(cfg_err), .q_cur(q_cur),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_wrap(rsp_wrap), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic void model(input int o, a, b, q, output int d, output int w, output int e);
        int raw;
        raw = o ? a - b : a + b;
        e = (a >= q) || (b >= q);
        d = e ? 0 : ((raw % q) + q) % q;
        w = !e && (raw < 0 || raw >= q);
    endfunction

    function automatic int opnd(input int q);
        return ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, q - 1));
    endfunction

    task automatic check_reset_outs(input string tag);
        check({tag, "_ack"}, {ack0, ack1}, 0);
        check({tag, "_rsp"}, {rsp_valid, rsp_id, rsp_data, rsp_wrap, rsp_err}, 0);
        check({tag, "_cfg_err"}, cfg_err, 0);
        check({tag, "_q_cur"}, q_cur, 7);
    endtask

    // cm: 0 no config write, 1 write together with the request, 2 write during the first EXEC
    task automatic round(input bit r0, r1, o0, o1, input int x0, y0, x1, y1, cm, cv);
        int ord[2], qa[2], qb[2], qo[2];
        int n, got, acks, ack_cyc, first_cyc, eq, d, w, e, i;
        bit cok;
        qa[0] = x0; qa[1] = x1; qb[0] = y0; qb[1] = y1; qo[0] = o0; qo[1] = o1;
        cok = (cv >= 2) && (cv <= 8);
        if (cm == 1 && cok) mq = cv;
        eq = mq;
        if (r0 && r1) begin
            ord[0] = 1 - mlast; ord[1] = mlast; n = 2;
        end else begin
            ord[0] = r1 ? 1 : 0; ord[1] = ord[0]; n = 1;
        end
        mlast = ord[n-1];
        @(negedge clk);
        req0 = r0; req1 = r1; op0 = o0; op1 = o1;
        a0 = 5'(x0); b0 = 5'(y0); a1 = 5'(x1); b1 = 5'(y1);
        if (cm == 1) begin cfg_we = 1'b1; cfg_q = 5'(cv); end
        first_cyc = cyc + 1 + ((cm == 1) ? 1 : 0);
        got = 0; acks = 0; ack_cyc = 0;
        for (int t = 0; t < 30 && got < n; t++) begin
            @(negedge clk);
            if (cfg_we) begin
                cfg_we = 1'b0;
                check("cfg_err", cfg_err, (cm == 1) ? !cok : 1);
                check("q_cur", q_cur, mq);
            end
            if (ack0 || ack1) begin
                check("ack_onehot", ack0 ^ ack1, 1);
                if (acks >= n) check("ack_extra", acks, n - 1);
                else check("ack_id", ack1, ord[acks]);
                check("ack_cycle", cyc, (acks == 0) ? first_cyc : ack_cyc + 3);
                ack_cyc = cyc;
                acks++;
                if (ack0) req0 = 1'b0;
                if (ack1) req1 = 1'b0;
                if (cm == 2 && acks == 1) begin cfg_we = 1'b1; cfg_q = 5'(cv); end
            end
            if (rsp_valid) begin
                if (got < n) begin
                    i = ord[got];
                    model(qo[i], qa[i], qb[i], eq, d, w, e);
                    check("rsp_cycle", cyc, ack_cyc + 1);
                    check("rsp_id", rsp_id, i);
                    check("rsp_data", rsp_data, d);
                    check("rsp_wrap", rsp_wrap, w);
                    check("rsp_err", rsp_err, e);
                end
                got++;
            end
        end
        check("rsp_count", got, n);
        check("ack_count", acks, n);
    endtask

    initial begin
        int seen, m, u, cm, cv, nq;
        #1 rst = 1'b1;
        #2 check_reset_outs("por");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        round(1, 1, 1, 0, 1, 3, 2, 3, 0, 0);
        round(1, 0, 0, 0, 5, 4, 0, 0, 0, 0);
        round(1, 1, 0, 1, 2, 2, 6, 1, 0, 0);
        round(0, 1, 0, 0, 0, 0, 4, 3, 1, 5);
        round(1, 0, 0, 0, 1, 2, 0, 0, 1, 9);
        round(1, 0, 1, 0, 0, 4, 0, 0, 2, 6);
        round(1, 0, 0, 0, 7, 1, 0, 0, 1, 7);
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1; op0 = 1'b0; op1 = 1'b0;
        a0 = 5'd1; b0 = 5'd2; a1 = 5'd3; b1 = 5'd1;
        @(negedge clk);
        check("mid_ack", ack0 | ack1, 1);
        req0 = 1'b0; req1 = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_outs("mid");
        @(negedge clk);
        rst = 1'b0;
        mq = 7; mlast = 1; seen = 0;
        repeat (3) begin
            @(negedge clk);
            seen += rsp_valid;
        end
        check("mid_no_rsp", seen, 0);
        round(1, 1, 0, 0, 2, 2, 1, 1, 0, 0);
        for (int k = 0; k < 40; k++) begin
            m = $urandom_range(1, 3);
            u = $urandom_range(0, 9);
            cm = 0; cv = 0;
            if (u == 0) begin cm = 1; cv = $urandom_range(0, 10); end
            else if (u == 1) begin cm = 2; cv = $urandom_range(2, 8); end
            nq = (cm == 1 && cv >= 2 && cv <= 8) ? cv : mq;
            round(m[0], m[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  opnd(nq), opnd(nq), opnd(nq), opnd(nq), cm, cv);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
